// File: rtl/td4_prog_loader.sv
// td4_prog_loader: 2**ADDR_W x 8 writable program store for the TD4 core.
// A byte-stream loader fills the store while the core is held in reset, and
// releases the core once the image is complete.
// Build option: define TD4_LOADER_CHECKSUM_EN to require a trailing 8-bit
// sum byte (CHECK/ERROR states). Left undefined, the load ends on the last
// program byte and load_error is tied low.
module td4_prog_loader #(
    parameter int ADDR_W = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [7:0]        load_data,
    output logic              load_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data,
    output logic              core_reset_n,
    output logic              load_done,
    output logic              load_error
);

    localparam int DEPTH = 2**ADDR_W;

`ifdef TD4_LOADER_CHECKSUM_EN
    typedef enum logic [1:0] {S_RUN, S_LOAD, S_CHECK, S_ERROR} state_t;
`else
    typedef enum logic {S_RUN, S_LOAD} state_t;
`endif

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] wr_addr, wr_addr_nxt;
    logic              done_nxt;
    logic              accept;
    logic              wr_en;
`ifdef TD4_LOADER_CHECKSUM_EN
    logic [7:0]        sum, sum_nxt;
`endif

    // Power-up image is all zeros; reset deliberately leaves it alone.
    logic [7:0] mem [DEPTH] = '{default: 8'h00};

    assign accept = load_valid & load_ready;

    // State register plus loader bookkeeping; core reset follows the pre-edge state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= S_RUN;
            wr_addr      <= '0;
            load_done    <= 1'b0;
            core_reset_n <= 1'b0;
`ifdef TD4_LOADER_CHECKSUM_EN
            sum          <= 8'h00;
`endif
        end else begin
            state        <= state_nxt;
            wr_addr      <= wr_addr_nxt;
            load_done    <= done_nxt;
            core_reset_n <= (state == S_RUN);
`ifdef TD4_LOADER_CHECKSUM_EN
            sum          <= sum_nxt;
`endif
        end
    end

    // Next-state logic; load_start from any state wins over a same-cycle byte.
    always_comb begin
        state_nxt   = state;
        wr_addr_nxt = wr_addr;
        done_nxt    = 1'b0;
`ifdef TD4_LOADER_CHECKSUM_EN
        sum_nxt     = sum;
`endif
        if (load_start) begin
            state_nxt   = S_LOAD;
            wr_addr_nxt = '0;
`ifdef TD4_LOADER_CHECKSUM_EN
            sum_nxt     = 8'h00;
`endif
        end else begin
            case (state)
                S_LOAD: begin
                    if (accept) begin
                        wr_addr_nxt = wr_addr + ADDR_W'(1);
`ifdef TD4_LOADER_CHECKSUM_EN
                        sum_nxt = sum + load_data;
                        if (wr_addr == '1)
                            state_nxt = S_CHECK;
`else
                        if (wr_addr == '1) begin
                            state_nxt = S_RUN;
                            done_nxt  = 1'b1;
                        end
`endif
                    end
                end
`ifdef TD4_LOADER_CHECKSUM_EN
                S_CHECK: begin
                    if (accept) begin
                        if (load_data == sum) begin
                            state_nxt = S_RUN;
                            done_nxt  = 1'b1;
                        end else begin
                            state_nxt = S_ERROR;
                        end
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    // Outputs decoded from state; write strobe drops on restart or reset.
    always_comb begin
        load_ready = (state == S_LOAD);
        load_error = 1'b0;
`ifdef TD4_LOADER_CHECKSUM_EN
        load_ready = (state == S_LOAD) || (state == S_CHECK);
        load_error = (state == S_ERROR);
`endif
        wr_en = (state == S_LOAD) && accept && !load_start && !reset;
    end

    // Program store write port; the checksum byte never reaches here.
    always_ff @(posedge clock) begin
        if (wr_en)
            mem[wr_addr] <= load_data;
    end

    assign rd_data = mem[rd_addr];

endmodule
